// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings, FSM state type and helpers for the
//               byte-serial load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } lsu_state_t;

    // Number of byte beats for a transfer size
    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    // Reserved size is treated as a misalignment so it never touches memory
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return |addr_lo;
            default: return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_extend.sv
`default_nettype none
// ============================================================================
// Module      : lsu_extend
// Description : Combinational sign/zero extension of the load accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_extend
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = acc;
        case (size)
            SZ_BYTE: data = {{(DATA_W-8){sign_ext & acc[7]}}, acc[7:0]};
            SZ_HALF: data = {{(DATA_W-16){sign_ext & acc[15]}}, acc[15:0]};
            default: data = acc;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Byte-serial big-endian load/store unit in front of a
//               byte-wide data memory, with alignment checking and stall.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              stall,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata
);

    lsu_state_t        r_state;
    lsu_state_t        w_next_state;

    logic              r_write;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_n;
    logic [1:0]        r_cnt;
    logic [DATA_W-1:0] r_acc;
    logic              r_misalign;

    logic              w_accept;
    logic              w_req_mis;
    logic              w_last;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [1:0]        w_byte_idx;
    logic [7:0]        w_store_byte;
    logic [DATA_W-1:0] w_ext;

    // Address bits above the memory range are architecturally ignored
    wire w_unused_addr = &{1'b0, req_addr[DATA_W-1:ADDR_W]};

    assign w_accept   = (r_state == ST_IDLE) && req_valid;
    assign w_req_mis  = is_misaligned(req_size, req_addr[1:0]);
    assign w_last     = ({1'b0, r_cnt} == (r_n - 3'd1));
    assign w_mem_addr = r_addr + ADDR_W'(r_cnt);

    // Big-endian: beat 0 (lowest address) carries the most significant byte
    assign w_byte_idx   = 2'(r_n - 3'd1 - {1'b0, r_cnt});
    assign w_store_byte = r_wdata[{w_byte_idx, 3'b000} +: 8];

    lsu_extend #(
        .DATA_W   (DATA_W)
    ) u_extend (
        .acc      (r_acc),
        .size     (r_size),
        .sign_ext (r_signed),
        .data     (w_ext)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        stall        = 1'b0;
        resp_valid   = 1'b0;
        resp_rdata   = '0;
        misalign     = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_we       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
                if (req_valid) begin
                    w_next_state = w_req_mis ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                stall    = 1'b1;
                mem_addr = w_mem_addr;
                if (r_write) begin
                    // Gate with reset so an aborted store never writes on the reset edge
                    mem_we    = reset_n;
                    mem_wdata = w_store_byte;
                end
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                resp_valid   = 1'b1;
                misalign     = r_misalign;
                resp_rdata   = (r_misalign || r_write) ? '0 : w_ext;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_write    <= 1'b0;
            r_size     <= SZ_BYTE;
            r_signed   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_n        <= 3'd1;
            r_cnt      <= 2'd0;
            r_acc      <= '0;
            r_misalign <= 1'b0;
        end else if (w_accept) begin
            r_write    <= req_write;
            r_size     <= req_size;
            r_signed   <= req_signed;
            r_addr     <= req_addr[ADDR_W-1:0];
            r_wdata    <= req_wdata;
            r_n        <= size_to_n(req_size);
            r_cnt      <= 2'd0;
            r_acc      <= '0;
            r_misalign <= w_req_mis;
        end else if (r_state == ST_ACCESS) begin
            r_cnt <= r_cnt + 2'd1;
            if (!r_write) begin
                r_acc <= {r_acc[DATA_W-9:0], mem_rdata};
            end
        end
    end

endmodule
`default_nettype wire
